range_max_scan: RTL and testbench
=================================

# range_max_scan

Sequencing stage directly downstream of the `range` Collatz-count RAM block. On a request it launches `range` on a base value, waits for `range` to fill its count RAM, and streams all `RAM_WORDS` counts back out through the `go`/`start`/`count` read port. While the counts stream it reduces them to a maximum count, that count's index and start value, and a total. Results are held for the bus/display logic until the next request.

## Interface
- `RAM_WORDS`, default 16: number of counts held by the attached `range`.
- `RAM_ADDR_BITS`, default 4: address width of the `range` RAM.
- `clk` in, 1: clock.
- `reset_n` in, 1: asynchronous, active-low reset.
- `req` in, 1: start a scan; sampled only in IDLE.
- `base` in, 32: first Collatz start value; captured on an accepted `req`.
- `busy` out, 1: scan in progress.
- `valid` out, 1: one-cycle pulse when the results update.
- `max_count` out, 16: largest count seen.
- `max_index` out, RAM_ADDR_BITS: RAM index of `max_count`.
- `max_n` out, 32: `base_q + max_index`, modulo 2^32.
- `sum` out, 16+RAM_ADDR_BITS: sum of all counts; cannot overflow.
- `r_go` out, 1: drives `range.go`.
- `r_start` out, 32: drives `range.start`.
- `r_done` in, 1: from `range.done`, a one-cycle pulse.
- `r_count` in, 16: from `range.count`, valid one cycle after the address is presented.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, READ, FLUSH, REPORT.
- **IDLE**
  - `r_go`=0 and `r_start`=0.
  - `r_done` is ignored, because a pulse may be left over from a run interrupted by reset.
  - `req`=1 captures `base` into `base_q`, clears the accumulators and moves to LAUNCH.
- **LAUNCH** (1 cycle): `r_go`=1, `r_start`=`base_q`, then WAIT.
- **WAIT**
  - `r_go`=0, `r_start` holds `base_q`.
  - `r_done`=1 sets `idx`=0 and moves to READ.
  - There is no timeout.
- **READ**
  - `r_start` = `idx` zero-extended to 32 bits, `r_go`=0.
  - Each cycle after the first, the `r_count` returned for address `idx-1` is accumulated.
  - `idx` increments each cycle. When `idx`==RAM_WORDS-1 is presented, go to FLUSH.
- **FLUSH** (1 cycle): accumulate the final word (address RAM_WORDS-1), then REPORT.
- **REPORT** (1 cycle): `valid`=1 and the output registers load from the accumulators, then IDLE.
- **Accumulate rule**
  - `sum += r_count`.
  - If `r_count > acc_max`, strictly greater, then `acc_max=r_count` and `acc_idx=address`.
  - Ties keep the lowest index. An all-zero RAM yields `max_count`=0 and `max_index`=0.
- **Boundaries**
  - `req` while `busy` is ignored, with no queueing.
  - `base` changing after capture has no effect.
  - `base`=0xFFFF_FFF8 with `max_index`=10 gives `max_n`=0x0000_0002 (wraps).
- **Reset**
  - Asserting reset, at any time and in any state, goes to IDLE immediately.
  - All outputs go to 0, including `r_go`, `r_start`, `busy`, `valid`, `max_count`, `max_index`, `max_n` and `sum`.
  - Reset has no effect on `range`. The next LAUNCH restarts it, because `go` has priority in `range`.

## Timing
- All outputs are registered; none is combinational from an input.
- Accepted `req` at edge 0 gives `r_go`=1 and `busy`=1 during cycle 1.
- `r_done` seen at edge k gives address 0 presented during cycle k+1. The last word is captured at edge k+RAM_WORDS+1 (FLUSH).
- `valid` is high during cycle k+RAM_WORDS+2, and the outputs are updated on that same edge.
- `busy` falls on the edge that ends REPORT. A `req` in the cycle after `valid` is accepted.
- Readback costs RAM_WORDS+2 cycles after `r_done`.

## Structure
- Package `range_pkg` holds:
  - `scan_state_t`, the enum of the six states;
  - `COUNT_W`=16;
  - `N_W`=32.
- One sub-module, `range_max_acc`:
  - inputs: clear, enable, `r_count`, address;
  - outputs: `acc_max`, `acc_idx`, `sum`.
- The top level holds the FSM, `idx` and the `base_q` registers. Integration instantiates `range` alongside it.

## Test plan
- **Basic scan.** Behavioural `range` model with RAM preloaded as mem[i]=i+3, RAM_WORDS=16, base=100. Required: `max_count`=18, `max_index`=15, `max_n`=115, `sum`=168, exactly one `valid` pulse, `r_go` high exactly 1 cycle.
- **Tie.** mem[2]=mem[9]=50, all others 7, base=1. Required: `max_index`=2, `max_n`=3, `sum`=198.
- **Wrap.** base=0xFFFF_FFF8, peak at index 10. Required: `max_n`=0x0000_0002.
- **Busy rejection.** Pulse `req` again during WAIT and during READ. Required: no second `r_go`, results from the first scan only.
- **Reset mid-READ.** `reset_n` low for 1 cycle while `idx`=7. Required: all outputs 0 the same cycle. A new `req` then completes correctly, and a stale `r_done` injected in IDLE is ignored.
- **Integrated.** Real `range` and `collatz`, base=1. Required: `max_count` and `max_index` match a software model of the `range` count definition; latency from `r_done` to `valid` is RAM_WORDS+2 cycles.

Source files
------------

// File: rtl/range_pkg.sv
// Shared types and widths for the range_max_scan readback stage.
package range_pkg;

  localparam int unsigned COUNT_W = 16;
  localparam int unsigned N_W     = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StRead,
    StFlush,
    StReport
  } scan_state_t;

endpackage

// File: rtl/range_max_scan_if.sv
// Request/result bus plus the read port toward the attached range block.
interface range_max_scan_if
  import range_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BITS = 4
);
  logic                             req;
  logic [N_W-1:0]                   base;
  logic                             busy;
  logic                             valid;
  logic [COUNT_W-1:0]               max_count;
  logic [RAM_ADDR_BITS-1:0]         max_index;
  logic [N_W-1:0]                   max_n;
  logic [COUNT_W+RAM_ADDR_BITS-1:0] sum;
  logic                             r_go;
  logic [N_W-1:0]                   r_start;
  logic                             r_done;
  logic [COUNT_W-1:0]               r_count;

  // Requester and range side.
  modport master (
    output req, base, r_done, r_count,
    input  busy, valid, max_count, max_index, max_n, sum, r_go, r_start
  );

  // The scan stage.
  modport slave (
    input  req, base, r_done, r_count,
    output busy, valid, max_count, max_index, max_n, sum, r_go, r_start
  );
endinterface

// File: rtl/range_max_acc.sv
// Running max/argmax/sum over the streamed counts; outputs include the word being accumulated.
module range_max_acc
  import range_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BITS = 4
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic                             enable,
  input  logic [COUNT_W-1:0]               r_count,
  input  logic [RAM_ADDR_BITS-1:0]         addr,
  output logic [COUNT_W-1:0]               acc_max,
  output logic [RAM_ADDR_BITS-1:0]         acc_idx,
  output logic [COUNT_W+RAM_ADDR_BITS-1:0] sum
);
  logic [COUNT_W-1:0]               max_q;
  logic [RAM_ADDR_BITS-1:0]         idx_q;
  logic [COUNT_W+RAM_ADDR_BITS-1:0] sum_q;

  // Strictly greater keeps the lowest index on ties.
  always_comb begin
    acc_max = max_q;
    acc_idx = idx_q;
    sum     = sum_q;
    if (enable) begin
      sum = sum_q + {{RAM_ADDR_BITS{1'b0}}, r_count};
      if (r_count > max_q) begin
        acc_max = r_count;
        acc_idx = addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
    end else if (clear) begin
      max_q <= '0;
      idx_q <= '0;
      sum_q <= '0;
    end else begin
      max_q <= acc_max;
      idx_q <= acc_idx;
      sum_q <= sum;
    end
  end
endmodule

// File: rtl/range_max_scan.sv
// Launches range, streams its count RAM back and reports max count, its index/start value and sum.
module range_max_scan
  import range_pkg::*;
#(
  parameter int unsigned RAM_WORDS     = 16,
  parameter int unsigned RAM_ADDR_BITS = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  range_max_scan_if.slave bus
);
  localparam logic [RAM_ADDR_BITS-1:0] LastIdx = RAM_ADDR_BITS'(RAM_WORDS - 1);
  localparam logic [RAM_ADDR_BITS-1:0] IdxOne  = RAM_ADDR_BITS'(1);

  scan_state_t                      state_q, state_d;
  logic [RAM_ADDR_BITS-1:0]         idx_q, idx_d;
  logic [N_W-1:0]                   base_q, base_d;
  logic                             acc_clear, acc_en, load_results;
  logic [RAM_ADDR_BITS-1:0]         acc_addr;
  logic [COUNT_W-1:0]               acc_max;
  logic [RAM_ADDR_BITS-1:0]         acc_idx;
  logic [COUNT_W+RAM_ADDR_BITS-1:0] acc_sum;
  logic                             r_go_d;
  logic [N_W-1:0]                   r_start_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    base_d       = base_q;
    acc_clear    = 1'b0;
    acc_en       = 1'b0;
    acc_addr     = idx_q - IdxOne;
    load_results = 1'b0;
    unique case (state_q)
      // r_done is deliberately ignored here: it may be left over from a run cut short by reset.
      StIdle: begin
        if (bus.req) begin
          base_d    = bus.base;
          acc_clear = 1'b1;
          state_d   = StLaunch;
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        if (bus.r_done) begin
          idx_d   = '0;
          state_d = StRead;
        end
      end
      // RAM read data lags the address by one cycle, so word idx-1 arrives now.
      StRead: begin
        acc_en = (idx_q != '0);
        if (idx_q == LastIdx) state_d = StFlush;
        else                  idx_d   = idx_q + IdxOne;
      end
      StFlush: begin
        acc_en       = 1'b1;
        acc_addr     = idx_q;
        load_results = 1'b1;
        state_d      = StReport;
      end
      StReport: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    r_go_d    = (state_d == StLaunch);
    r_start_d = '0;
    unique case (state_d)
      StLaunch: r_start_d = base_d;
      StWait:   r_start_d = base_q;
      StRead:   r_start_d = {{(N_W - RAM_ADDR_BITS){1'b0}}, idx_d};
      StFlush:  r_start_d = bus.r_start;
      default:  r_start_d = '0;
    endcase
  end

  range_max_acc #(
    .RAM_ADDR_BITS(RAM_ADDR_BITS)
  ) u_acc (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (acc_clear),
    .enable (acc_en),
    .r_count(bus.r_count),
    .addr   (acc_addr),
    .acc_max(acc_max),
    .acc_idx(acc_idx),
    .sum    (acc_sum)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      base_q        <= '0;
      bus.r_go      <= 1'b0;
      bus.r_start   <= '0;
      bus.busy      <= 1'b0;
      bus.valid     <= 1'b0;
      bus.max_count <= '0;
      bus.max_index <= '0;
      bus.max_n     <= '0;
      bus.sum       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      bus.r_go    <= r_go_d;
      bus.r_start <= r_start_d;
      bus.busy    <= (state_d != StIdle);
      bus.valid   <= load_results;
      if (load_results) begin
        bus.max_count <= acc_max;
        bus.max_index <= acc_idx;
        bus.max_n     <= base_q + {{(N_W - RAM_ADDR_BITS){1'b0}}, acc_idx};
        bus.sum       <= acc_sum;
      end
    end
  end
endmodule

// File: tb/tb_range_max_scan.sv
// Scoreboard bench for range_max_scan against a behavioural range RAM model.
module tb_range_max_scan;

  localparam int unsigned WORDS = 16;

  typedef struct packed {
    logic [15:0] max_count;
    logic [3:0]  max_index;
    logic [31:0] max_n;
    logic [19:0] sum;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  range_max_scan_if #(.RAM_ADDR_BITS(4)) bus ();

  range_max_scan #(
    .RAM_WORDS    (WORDS),
    .RAM_ADDR_BITS(4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Behavioural range: registered RAM read, done pulse a few cycles after go.
  logic [15:0] mem [WORDS];
  logic        done_model = 1'b0;
  logic        done_inject = 1'b0;
  int          done_cnt = 0;

  always @(posedge clk) begin
    bus.r_count <= mem[bus.r_start[3:0]];
    if (bus.r_go)          done_cnt <= 5;
    else if (done_cnt != 0) done_cnt <= done_cnt - 1;
    done_model <= (done_cnt == 1) && !bus.r_go;
  end
  assign bus.r_done = done_model | done_inject;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  int   go_seen = 0;
  int   valid_seen = 0;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] b);
    exp_t e;
    e = '0;
    for (int i = 0; i < WORDS; i++) begin
      e.sum = e.sum + {4'd0, mem[i]};
      if (mem[i] > e.max_count) begin
        e.max_count = mem[i];
        e.max_index = i[3:0];
      end
    end
    e.max_n = b + {28'd0, e.max_index};
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (bus.r_done && bus.busy) done_cyc = cyc;
    if (bus.r_go) go_seen++;
    if (bus.valid) begin
      valid_seen++;
      check("latency", cyc - done_cyc, WORDS + 2);
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("max_count", bus.max_count, e.max_count);
        check("max_index", bus.max_index, e.max_index);
        check("max_n", bus.max_n, e.max_n);
        check("sum", bus.sum, e.sum);
      end
    end
  end

  task automatic scan(input logic [31:0] b, input bit disturb);
    int v0;
    int g0;
    int n;
    v0 = valid_seen;
    g0 = go_seen;
    exp_q.push_back(model(b));
    @(negedge clk);
    bus.req  = 1'b1;
    bus.base = b;
    @(negedge clk);
    bus.req = 1'b0;
    if (disturb) begin
      @(negedge clk);
      bus.req  = 1'b1;
      bus.base = 32'h0000_1234;
      @(negedge clk);
      bus.req = 1'b0;
      n = 0;
      while (!(bus.busy && bus.r_start == 32'd3) && n < 100) begin
        @(negedge clk);
        n++;
      end
      check("reach_read", n < 100, 1);
      bus.req = 1'b1;
      @(negedge clk);
      bus.req = 1'b0;
    end
    n = 0;
    while (valid_seen == v0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("scan_done", valid_seen != v0, 1);
    repeat (3) @(negedge clk);
    check("valid_pulses", valid_seen - v0, 1);
    check("go_pulses", go_seen - g0, 1);
    check("idle_after", bus.busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_valid"}, bus.valid, 0);
    check({tag, "_r_go"}, bus.r_go, 0);
    check({tag, "_r_start"}, bus.r_start, 0);
    check({tag, "_max_count"}, bus.max_count, 0);
    check({tag, "_max_index"}, bus.max_index, 0);
    check({tag, "_max_n"}, bus.max_n, 0);
    check({tag, "_sum"}, bus.sum, 0);
  endtask

  initial begin
    int n;
    bus.req  = 1'b0;
    bus.base = '0;
    for (int i = 0; i < WORDS; i++) mem[i] = 16'(i + 3);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic ascending RAM.
    scan(32'd100, 1'b0);
    check("basic_max_count", bus.max_count, 18);
    check("basic_max_index", bus.max_index, 15);
    check("basic_max_n", bus.max_n, 115);
    check("basic_sum", bus.sum, 168);

    // Tie keeps lowest index.
    for (int i = 0; i < WORDS; i++) mem[i] = 16'd7;
    mem[2] = 16'd50;
    mem[9] = 16'd50;
    scan(32'd1, 1'b0);
    check("tie_max_index", bus.max_index, 2);
    check("tie_max_n", bus.max_n, 3);
    check("tie_sum", bus.sum, 198);

    // max_n wraps modulo 2^32.
    for (int i = 0; i < WORDS; i++) mem[i] = 16'd1;
    mem[10] = 16'd500;
    scan(32'hFFFF_FFF8, 1'b0);
    check("wrap_max_n", bus.max_n, 32'h0000_0002);

    // All-zero RAM.
    for (int i = 0; i < WORDS; i++) mem[i] = 16'd0;
    scan(32'd77, 1'b0);
    check("zero_max_count", bus.max_count, 0);
    check("zero_max_index", bus.max_index, 0);

    // req pulses during WAIT and READ must be ignored.
    for (int i = 0; i < WORDS; i++) mem[i] = 16'((i * 37) % 29 + 1);
    scan(32'd200, 1'b1);

    // Reset while address 7 is presented.
    for (int i = 0; i < WORDS; i++) mem[i] = 16'(i + 3);
    exp_q.push_back(model(32'd100));
    @(negedge clk);
    bus.req  = 1'b1;
    bus.base = 32'd100;
    @(negedge clk);
    bus.req = 1'b0;
    n = 0;
    while (!(bus.busy && bus.r_start == 32'd7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_idx7", n < 100, 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    done_inject = 1'b1;
    @(negedge clk);
    done_inject = 1'b0;
    repeat (3) @(negedge clk);
    check("stale_done_busy", bus.busy, 0);
    check("stale_done_go", bus.r_go, 0);
    check("stale_done_valid", valid_seen, 5);
    scan(32'd100, 1'b0);
    check("post_reset_max_n", bus.max_n, 115);
    check("post_reset_sum", bus.sum, 168);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
